// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads three consecutive operand words (a, b, c)
// starting at pc, with an unbounded-wait memory handshake.
module instr_fetch #(
    parameter logic [63:0] RESET_PC   = 64'd0,
    parameter int          WORD_BYTES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] next_pc,
    input  logic        pc_we,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ack,
    output logic [63:0] pc,
    output logic [63:0] mem_addr,
    output logic        mem_req,
    output logic [63:0] a,
    output logic [63:0] b,
    output logic [63:0] c,
    output logic        busy,
    output logic        fetch_done,
    output logic        fault
);

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        RD_C,
        DONE
    } state_t;

    localparam logic [63:0] STRIDE  = 64'(WORD_BYTES);
    localparam logic [63:0] STRIDE2 = 64'(2 * WORD_BYTES);

    state_t      state;
    state_t      state_next;
    logic [63:0] eff_pc;
    logic        eff_aligned;
    logic        accept;
    logic        reject;

    // A same-cycle pc load is what the fetch (or alignment check) sees.
    assign eff_pc      = pc_we ? next_pc : pc;
    assign eff_aligned = ((eff_pc % STRIDE) == 64'd0);
    assign accept      = (state == IDLE) && start && eff_aligned;
    assign reject      = (state == IDLE) && start && !eff_aligned;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_addr   = pc;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = RD_A;
                end
            end
            RD_A: begin
                mem_req  = 1'b1;
                mem_addr = pc;
                if (mem_ack) begin
                    state_next = RD_B;
                end
            end
            RD_B: begin
                mem_req  = 1'b1;
                mem_addr = pc + STRIDE;
                if (mem_ack) begin
                    state_next = RD_C;
                end
            end
            RD_C: begin
                mem_req  = 1'b1;
                mem_addr = pc + STRIDE2;
                if (mem_ack) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= RESET_PC;
            fault <= 1'b0;
        end else begin
            fault <= reject;
            if ((state == IDLE) && pc_we) begin
                pc <= next_pc;
            end
        end
    end

    // Operands are only overwritten by an acknowledged read in their own state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a <= 64'd0;
            b <= 64'd0;
            c <= 64'd0;
        end else if (mem_ack) begin
            if (state == RD_A) a <= mem_rdata;
            if (state == RD_B) b <= mem_rdata;
            if (state == RD_C) c <= mem_rdata;
        end
    end

    assign busy       = (state != IDLE);
    assign fetch_done = (state == DONE);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] next_pc;
    logic        pc_we;
    logic [63:0] mem_rdata;
    logic        mem_ack;
    logic [63:0] pc;
    logic [63:0] mem_addr;
    logic        mem_req;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;
    logic        busy;
    logic        fetch_done;
    logic        fault;

    int checks   = 0;
    int failures = 0;

    instr_fetch #(
        .RESET_PC  (64'd0),
        .WORD_BYTES(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .next_pc   (next_pc),
        .pc_we     (pc_we),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .pc        (pc),
        .mem_addr  (mem_addr),
        .mem_req   (mem_req),
        .a         (a),
        .b         (b),
        .c         (c),
        .busy      (busy),
        .fetch_done(fetch_done),
        .fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; pc_we = 1'b0; next_pc = 64'd0;
        mem_rdata = 64'd0; mem_ack = 1'b0;
        #3;
        checks++; if (pc !== 64'd0) begin failures++; $display("[TB] FAIL reset_pc got=%h exp=%h", pc, 64'd0); end
        checks++; if ({a, b, c} !== 192'd0) begin failures++; $display("[TB] FAIL reset_abc got=%h %h %h exp=0", a, b, c); end
        checks++; if ({mem_req, busy, fetch_done, fault} !== 4'b0000) begin failures++; $display("[TB] FAIL reset_flags got=%b exp=0000", {mem_req, busy, fetch_done, fault}); end
        tick();
        tick();
        rst = 1'b0;
        checks++; if (mem_addr !== 64'd0) begin failures++; $display("[TB] FAIL reset_addr got=%h exp=0", mem_addr); end
    endtask

    task automatic test_zero_wait;
        logic [63:0] exp_addr [3];
        logic [63:0] data [3];
        exp_addr[0] = 64'd0;  exp_addr[1] = 64'd8;  exp_addr[2] = 64'd16;
        data[0]     = 64'd11; data[1]     = 64'd22; data[2]     = 64'd33;
        start = 1'b1; mem_ack = 1'b1; mem_rdata = data[0];
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_rdata = data[i];
            checks++; if (mem_req !== 1'b1 || mem_addr !== exp_addr[i] || busy !== 1'b1)
                begin failures++; $display("[TB] FAIL zw_addr%0d got req=%b addr=%h busy=%b exp req=1 addr=%h busy=1", i, mem_req, mem_addr, busy, exp_addr[i]); end
            checks++; if (fetch_done !== 1'b0) begin failures++; $display("[TB] FAIL zw_early_done cycle%0d got=%b exp=0", i + 1, fetch_done); end
            tick();
        end
        checks++; if (fetch_done !== 1'b1) begin failures++; $display("[TB] FAIL zw_done_cycle4 got=%b exp=1", fetch_done); end
        checks++; if (a !== 64'd11 || b !== 64'd22 || c !== 64'd33) begin failures++; $display("[TB] FAIL zw_abc got=%0d %0d %0d exp=11 22 33", a, b, c); end
        checks++; if (mem_req !== 1'b0 || mem_addr !== 64'd0) begin failures++; $display("[TB] FAIL zw_done_req got req=%b addr=%h exp req=0 addr=0", mem_req, mem_addr); end
        mem_rdata = 64'hDEAD;
        tick();
        checks++; if (fetch_done !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL zw_idle got done=%b busy=%b exp 0 0", fetch_done, busy); end
        tick();
        checks++; if (a !== 64'd11 || b !== 64'd22 || c !== 64'd33) begin failures++; $display("[TB] FAIL idle_ack_ignored got=%0d %0d %0d exp=11 22 33", a, b, c); end
    endtask

    task automatic test_wait_states;
        mem_ack = 1'b1; mem_rdata = 64'hA1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++; if (a !== 64'hA1) begin failures++; $display("[TB] FAIL ws_a got=%h exp=a1", a); end
        mem_ack = 1'b0; mem_rdata = 64'hBAD;
        pc_we = 1'b1; next_pc = 64'h100; start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (mem_req !== 1'b1 || mem_addr !== 64'd8) begin failures++; $display("[TB] FAIL ws_hold%0d got req=%b addr=%h exp req=1 addr=8", i, mem_req, mem_addr); end
            tick();
            checks++; if (b !== 64'd22 || pc !== 64'd0) begin failures++; $display("[TB] FAIL ws_stable%0d got b=%h pc=%h exp b=16 pc=0", i, b, pc); end
        end
        mem_ack = 1'b1; mem_rdata = 64'hB2;
        tick();
        checks++; if (b !== 64'hB2 || mem_addr !== 64'd16) begin failures++; $display("[TB] FAIL ws_b got b=%h addr=%h exp b=b2 addr=10", b, mem_addr); end
        mem_rdata = 64'hC3;
        tick();
        checks++; if (fetch_done !== 1'b1 || c !== 64'hC3 || pc !== 64'd0) begin failures++; $display("[TB] FAIL ws_done got done=%b c=%h pc=%h exp 1 c3 0", fetch_done, c, pc); end
        tick();
        pc_we = 1'b0; start = 1'b0; mem_ack = 1'b0;
        checks++; if (busy !== 1'b0 || pc !== 64'd0) begin failures++; $display("[TB] FAIL ws_end got busy=%b pc=%h exp 0 0", busy, pc); end
    endtask

    task automatic test_load_and_start;
        pc_we = 1'b1; next_pc = 64'h40; start = 1'b1; mem_ack = 1'b1; mem_rdata = 64'h5;
        tick();
        pc_we = 1'b0; start = 1'b0;
        checks++; if (pc !== 64'h40 || mem_addr !== 64'h40 || mem_req !== 1'b1) begin failures++; $display("[TB] FAIL ls_a got pc=%h addr=%h req=%b exp 40 40 1", pc, mem_addr, mem_req); end
        tick();
        checks++; if (mem_addr !== 64'h48) begin failures++; $display("[TB] FAIL ls_b got=%h exp=48", mem_addr); end
        tick();
        checks++; if (mem_addr !== 64'h50) begin failures++; $display("[TB] FAIL ls_c got=%h exp=50", mem_addr); end
        tick();
        tick();
        mem_ack = 1'b0;
    endtask

    task automatic test_misaligned;
        pc_we = 1'b1; next_pc = 64'h13; start = 1'b1;
        tick();
        pc_we = 1'b0; start = 1'b0;
        checks++; if (pc !== 64'h13 || fault !== 1'b1 || busy !== 1'b0 || mem_req !== 1'b0)
            begin failures++; $display("[TB] FAIL mis_load got pc=%h fault=%b busy=%b req=%b exp 13 1 0 0", pc, fault, busy, mem_req); end
        tick();
        checks++; if (fault !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL mis_pulse got fault=%b busy=%b exp 0 0", fault, busy); end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (fault !== 1'b1 || busy !== 1'b0) begin failures++; $display("[TB] FAIL mis_pc got fault=%b busy=%b exp 1 0", fault, busy); end
        tick();
        checks++; if (fault !== 1'b0) begin failures++; $display("[TB] FAIL mis_pc_pulse got=%b exp=0", fault); end
    endtask

    task automatic test_wraparound;
        pc_we = 1'b1; next_pc = 64'hFFFF_FFFF_FFFF_FFF8; start = 1'b1; mem_ack = 1'b1;
        tick();
        pc_we = 1'b0; start = 1'b0;
        checks++; if (mem_addr !== 64'hFFFF_FFFF_FFFF_FFF8) begin failures++; $display("[TB] FAIL wrap_a got=%h exp=fffffffffffffff8", mem_addr); end
        tick();
        checks++; if (mem_addr !== 64'h0) begin failures++; $display("[TB] FAIL wrap_b got=%h exp=0", mem_addr); end
        tick();
        checks++; if (mem_addr !== 64'h8) begin failures++; $display("[TB] FAIL wrap_c got=%h exp=8", mem_addr); end
        tick();
        tick();
        mem_ack = 1'b0;
    endtask

    task automatic test_async_reset;
        logic saw_done;
        saw_done = 1'b0;
        pc_we = 1'b1; next_pc = 64'h40; start = 1'b1; mem_ack = 1'b1; mem_rdata = 64'h77;
        tick();
        pc_we = 1'b0; start = 1'b0;
        tick();
        tick();
        mem_ack = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h50) begin failures++; $display("[TB] FAIL ar_in_rdc got req=%b addr=%h exp 1 50", mem_req, mem_addr); end
        #2 rst = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0 || busy !== 1'b0 || pc !== 64'd0 || a !== 64'd0)
            begin failures++; $display("[TB] FAIL ar_immediate got req=%b busy=%b pc=%h a=%h exp 0 0 0 0", mem_req, busy, pc, a); end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (fetch_done) saw_done = 1'b1;
            tick();
        end
        checks++; if (saw_done !== 1'b0) begin failures++; $display("[TB] FAIL ar_no_done got=%b exp=0", saw_done); end
        start = 1'b1; mem_ack = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (mem_addr !== 64'd0 || mem_req !== 1'b1) begin failures++; $display("[TB] FAIL ar_refetch got addr=%h req=%b exp 0 1", mem_addr, mem_req); end
        tick();
        tick();
        tick();
        mem_ack = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_load_and_start();
        test_misaligned();
        test_wraparound();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
